// File: rtl/mux2_arbiter_ctrl.sv
// Round-robin arbiter sharing one 2:1 data mux between two valid/ready requesters, with burst-bounded grants.
// Define MUX2_ARB_FIXED_PRIO_EN for strict port-0 priority instead of round-robin.
module mux2_arbiter_ctrl #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              select,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              select_q, select_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              out_free_s;
    logic              in0_ready_s, in1_ready_s;
    logic              acc0_s, acc1_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              burst_done_s;
    logic [DATA_W-1:0] mux_data_s;

    // Handshake decode: ready depends only on registered state and out_ready.
    always_comb begin
        out_free_s   = !out_valid_q || out_ready;
        in0_ready_s  = (state_q == GRANT0) && out_free_s;
        in1_ready_s  = (state_q == GRANT1) && out_free_s;
        acc0_s       = in0_valid && in0_ready_s;
        acc1_s       = in1_valid && in1_ready_s;
        cnt_inc_s    = cnt_q + CNT_W'(1);
        burst_done_s = (acc0_s || acc1_s) && (cnt_inc_s == CNT_MAX);
        mux_data_s   = select_q ? in1_data : in0_data;
    end

    // Arbitration FSM next-state, burst counter and grant history.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in0_valid && in1_valid) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
                    state_d = GRANT0;
`else
                    state_d = last_grant_q ? GRANT0 : GRANT1;
`endif
                end else if (in0_valid) begin
                    state_d = GRANT0;
                end else if (in1_valid) begin
                    state_d = GRANT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT0: begin
                if (burst_done_s || !in0_valid) begin
                    last_grant_d = 1'b0;
                    cnt_d        = '0;
`ifdef MUX2_ARB_FIXED_PRIO_EN
                    // Port 1 only gets in once port 0 has nothing left to send.
                    state_d = (in1_valid && !in0_valid) ? GRANT1 : IDLE;
`else
                    state_d = in1_valid ? GRANT1 : IDLE;
`endif
                end else if (acc0_s) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            GRANT1: begin
                if (burst_done_s || !in1_valid) begin
                    last_grant_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = in0_valid ? GRANT0 : IDLE;
                end else if (acc1_s) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Select, busy and output-stage next values; select moves only with a grant change.
    always_comb begin
        busy_d = (state_d != IDLE);
        if (state_d == GRANT1) begin
            select_d = 1'b1;
        end else if (state_d == GRANT0) begin
            select_d = 1'b0;
        end else begin
            select_d = select_q;
        end
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (acc0_s || acc1_s) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            select_q     <= 1'b0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            select_q     <= select_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign in0_ready = in0_ready_s;
    assign in1_ready = in1_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign select    = select_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mux2_arbiter_ctrl.sv
// Scoreboard bench for mux2_arbiter_ctrl: a MAX_BURST=4 instance and a MAX_BURST=1 instance.
module tb_mux2_arbiter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in0_valid, in1_valid, out_ready;
    logic [7:0] in0_data, in1_data;
    logic       in0_ready, in1_ready, out_valid, select, busy;
    logic [7:0] out_data;

    logic       b_in0_valid, b_in1_valid, b_out_ready;
    logic [7:0] b_in0_data, b_in1_data;
    logic       b_in0_ready, b_in1_ready, b_out_valid, b_select, b_busy;
    logic [7:0] b_out_data;

    mux2_arbiter_ctrl #(.DATA_W(8), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .select(select), .busy(busy)
    );

    mux2_arbiter_ctrl #(.DATA_W(8), .MAX_BURST(1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(b_in0_valid), .in0_data(b_in0_data), .in0_ready(b_in0_ready),
        .in1_valid(b_in1_valid), .in1_data(b_in1_data), .in1_ready(b_in1_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .select(b_select), .busy(b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q0[$], q1[$], qb0[$], qb1[$];
    logic [7:0] exp_q[$], expb_q[$];
    bit acc0_v, acc1_v, accb0_v, accb1_v;
    bit ordy_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: retire accepted beats, present queue heads, then sample handshakes mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (acc0_v)  void'(q0.pop_front());
        if (acc1_v)  void'(q1.pop_front());
        if (accb0_v) void'(qb0.pop_front());
        if (accb1_v) void'(qb1.pop_front());
        in0_valid   = (q0.size() > 0);
        in0_data    = (q0.size() > 0) ? q0[0] : 8'h00;
        in1_valid   = (q1.size() > 0);
        in1_data    = (q1.size() > 0) ? q1[0] : 8'h00;
        b_in0_valid = (qb0.size() > 0);
        b_in0_data  = (qb0.size() > 0) ? qb0[0] : 8'h00;
        b_in1_valid = (qb1.size() > 0);
        b_in1_data  = (qb1.size() > 0) ? qb1[0] : 8'h00;
        out_ready   = ordy_v;
        @(negedge clk);
        acc0_v  = in0_valid && in0_ready;
        acc1_v  = in1_valid && in1_ready;
        accb0_v = b_in0_valid && b_in0_ready;
        accb1_v = b_in1_valid && b_in1_ready;
    endtask

    // Monitor for the MAX_BURST=4 instance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_beat: unexpected beat 0x%0h, expected none at %0t", out_data, $time);
                end else begin
                    check("out_data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // Monitor for the MAX_BURST=1 instance.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && b_out_valid && b_out_ready) begin
                if (expb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b1_out_beat: unexpected beat 0x%0h, expected none at %0t", b_out_data, $time);
                end else begin
                    check("b1_out_data", {24'h0, b_out_data}, {24'h0, expb_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = 8'h00; in1_data = 8'h00;
        b_in0_valid = 1'b0; b_in1_valid = 1'b0; b_in0_data = 8'h00; b_in1_data = 8'h00;
        out_ready = 1'b1; b_out_ready = 1'b1; ordy_v = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_out_data",  {24'h0, out_data},  32'h0);
        check("rst_select",    {31'h0, select},    32'd0);
        check("rst_busy",      {31'h0, busy},      32'd0);
        check("rst_in0_ready", {31'h0, in0_ready}, 32'd0);
        check("rst_b1_valid",  {31'h0, b_out_valid}, 32'd0);

        // Single requester, two beats: grant at cycle 1, outputs at cycles 2 and 3.
        q0 = '{8'h11, 8'h22};
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        tick();
        check("c0_busy",      {31'h0, busy},      32'd0);
        check("c0_in0_ready", {31'h0, in0_ready}, 32'd0);
        tick();
        check("c1_busy",      {31'h0, busy},      32'd1);
        check("c1_select",    {31'h0, select},    32'd0);
        check("c1_in0_ready", {31'h0, in0_ready}, 32'd1);
        check("c1_out_valid", {31'h0, out_valid}, 32'd0);
        tick();
        check("c2_in0_ready", {31'h0, in0_ready}, 32'd1);
        check("c2_out_valid", {31'h0, out_valid}, 32'd1);
        tick();
        check("c3_out_valid", {31'h0, out_valid}, 32'd1);
        tick(); tick();
        check("t1_idle_busy", {31'h0, busy}, 32'd0);

        // Output stall with 0xA5 held; next beat rides the drain cycle.
        q0 = '{8'hA5, 8'hA6};
        exp_q.push_back(8'hA5); exp_q.push_back(8'hA6);
        tick(); tick();
        ordy_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_out_valid", {31'h0, out_valid}, 32'd1);
            check("stall_out_data",  {24'h0, out_data},  32'hA5);
            check("stall_in0_ready", {31'h0, in0_ready}, 32'd0);
            check("stall_busy",      {31'h0, busy},      32'd1);
        end
        ordy_v = 1'b1;
        tick();
        check("drain_in0_ready", {31'h0, in0_ready}, 32'd1);
        tick();
        check("drain_next_data", {24'h0, out_data}, 32'hA6);
        tick(); tick();

        // Port 0 drops valid after two beats while port 1 waits: immediate hand-over.
        q0 = '{8'h61, 8'h62};
        exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        exp_q.push_back(8'h71); exp_q.push_back(8'h72); exp_q.push_back(8'h73);
        tick(); tick();
        q1 = '{8'h71, 8'h72, 8'h73};
        tick(); tick();
        check("drop_c3_select", {31'h0, select}, 32'd0);
        tick();
        check("drop_c4_select",    {31'h0, select},    32'd1);
        check("drop_c4_in1_ready", {31'h0, in1_ready}, 32'd1);
        repeat (5) tick();

        // Both valid continuously: 4-beat bursts alternate with no bubble.
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'h80 + 8'(i));
            q1.push_back(8'h90 + 8'(i));
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h80 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h90 + 8'(i));
        for (int i = 4; i < 8; i++) exp_q.push_back(8'h80 + 8'(i));
        for (int i = 4; i < 8; i++) exp_q.push_back(8'h90 + 8'(i));
        tick();
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c <= 16) check("rr_select", {31'h0, select}, 32'(((c - 1) / 4) % 2));
            if (c >= 2)  check("rr_out_valid", {31'h0, out_valid}, 32'd1);
        end
        tick();
        check("rr_end_out_valid", {31'h0, out_valid}, 32'd0);
        tick(); tick();

        // Asynchronous reset on beat 2 of a burst.
        q0 = '{8'h31, 8'h32, 8'h33, 8'h34};
        exp_q.push_back(8'h31);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'h0, out_valid}, 32'd0);
        check("arst_select",    {31'h0, select},    32'd0);
        check("arst_busy",      {31'h0, busy},      32'd0);
        check("arst_in0_ready", {31'h0, in0_ready}, 32'd0);
        check("arst_exp_empty", 32'(exp_q.size()), 32'd0);
        q0.delete(); q1.delete();
        acc0_v = 1'b0; acc1_v = 1'b0; accb0_v = 1'b0; accb1_v = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q0 = '{8'h41, 8'h42};
        q1 = '{8'h51, 8'h52};
        exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        exp_q.push_back(8'h51); exp_q.push_back(8'h52);
        tick(); tick();
        check("post_rst_select",    {31'h0, select},    32'd0);
        check("post_rst_in0_ready", {31'h0, in0_ready}, 32'd1);
        repeat (7) tick();

        // MAX_BURST=1 instance: grants alternate every beat.
        for (int i = 0; i < 4; i++) begin
            qb0.push_back(8'hA0 + 8'(i));
            qb1.push_back(8'hB0 + 8'(i));
            expb_q.push_back(8'hA0 + 8'(i));
            expb_q.push_back(8'hB0 + 8'(i));
        end
        tick();
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c <= 8) check("b1_select", {31'h0, b_select}, 32'((c - 1) % 2));
            if (c >= 2) check("b1_out_valid", {31'h0, b_out_valid}, 32'd1);
        end
        repeat (3) tick();

        check("exp_q_drained",  32'(exp_q.size()),  32'd0);
        check("expb_q_drained", 32'(expb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
